// File: rtl/cipher_pkg.sv
// Shared types and keystream helpers for the dual XOR stream cipher.
// The LFSR helpers work on a fixed 64-bit container. Narrower registers are
// zero-extended into it. With zero-extended taps, the upper bits stay zero
// through the right shift, so one function serves every M up to 64.
package cipher_pkg;

    localparam int M_DEFAULT   = 40;
    localparam int CFG_LEN     = 4 * M_DEFAULT;
    localparam int CHAIN_PER_M = CFG_LEN / M_DEFAULT;
    localparam int LFSR_MAX    = 64;
    localparam int DATA_MAX    = 64;

    typedef logic [LFSR_MAX-1:0] lfsr_t;
    typedef logic [DATA_MAX-1:0] ks_word_t;

    typedef struct packed {
        lfsr_t next_s;
        logic  k;
    } step_t;

    typedef struct packed {
        lfsr_t    next_s;
        ks_word_t ks;
    } beat_ks_t;

    // One Galois right-shift step; the keystream bit is the bit shifted out.
    function automatic step_t lfsr_step(input lfsr_t s, input lfsr_t taps);
        step_t r;
        r.k      = s[0];
        r.next_s = (s >> 1) ^ (s[0] ? taps : '0);
        return r;
    endfunction

    // W unrolled steps; keystream bit i comes from step i (LSB first).
    function automatic beat_ks_t keystream_w(input lfsr_t s, input lfsr_t taps, input int w);
        beat_ks_t r;
        step_t    st;
        lfsr_t    cur;
        cur  = s;
        r.ks = '0;
        for (int i = 0; i < DATA_MAX; i++) begin
            if (i < w) begin
                st      = lfsr_step(cur, taps);
                r.ks[i] = st.k;
                cur     = st.next_s;
            end
        end
        r.next_s = cur;
        return r;
    endfunction

endpackage

// File: rtl/xor_keystream_path.sv
// One cipher direction: LFSR keystream state, frame counter, zero-lock flag
// and the registered XOR output. TX and RX are two instances of this block.
module xor_keystream_path
    import cipher_pkg::*;
#(
    parameter int             W            = 8,
    parameter int             M            = 40,
    parameter int             FRAME        = 0,
    parameter logic [M-1:0]   SEED_DEFAULT = M'(1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cfg_en,
    input  logic         resync,
    input  logic [M-1:0] taps,
    input  logic [M-1:0] seed,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         lock_err
);

    localparam int             FW         = (FRAME > 1) ? $clog2(FRAME) : 1;
    localparam logic [FW-1:0]  FRAME_LAST = (FRAME > 0) ? FW'(FRAME - 1) : '0;

    logic [M-1:0]  state_q, state_d;
    logic [FW-1:0] frame_q, frame_d;
    logic          lock_q, lock_d;
    logic          valid_q, valid_d;
    logic [W-1:0]  data_q, data_d;

    logic [M-1:0]  s_eff;
    beat_ks_t      ks_res;
    logic          frame_wrap;
    logic          path_unused;

    // An all-zero state would lock the LFSR, so it is replaced by 1 before use.
    always_comb begin
        s_eff      = (state_q == '0) ? M'(1) : state_q;
        ks_res     = keystream_w(lfsr_t'(s_eff), lfsr_t'(taps), W);
        frame_wrap = (FRAME > 0) && (frame_q == FRAME_LAST);
    end

    assign path_unused = ^ks_res;

    // Next state: config load > resync > frame wrap > normal advance.
    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        lock_d  = lock_q;
        valid_d = 1'b0;
        data_d  = data_q;
        if (cfg_en) begin
            state_d = seed;
            frame_d = '0;
            lock_d  = 1'b0;
        end else begin
            if (state_q == '0) begin
                lock_d = 1'b1;
            end
            if (in_valid) begin
                valid_d = 1'b1;
                data_d  = in_data ^ ks_res.ks[W-1:0];
                if (frame_wrap) begin
                    state_d = seed;
                    frame_d = '0;
                end else begin
                    state_d = ks_res.next_s[M-1:0];
                    frame_d = frame_q + FW'(1);
                end
            end
            if (resync) begin
                state_d = seed;
                frame_d = '0;
            end
        end
    end

    // Path registers with synchronous reset to the default seed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEED_DEFAULT;
            frame_q <= '0;
            lock_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            lock_q  <= lock_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign lock_err  = lock_q;

endmodule

// File: rtl/dual_xor_stream_cipher_w.sv
// Dual XOR stream cipher top. It holds the config scan chain
// {tx_taps, tx_seed, rx_taps, rx_seed} and the heartbeat counter, and it
// instantiates the TX and RX paths.
// cfg_o is a flop that carries the chain MSB, so on each shift it presents
// the bit that has just left the chain. The paths load their seed from the
// chain's next value. When cfg_en drops, the LFSR state therefore already
// matches the seed that was shifted in last.
module dual_xor_stream_cipher_w
    import cipher_pkg::*;
#(
    parameter int             W            = 8,
    parameter int             M            = M_DEFAULT,
    parameter int             FRAME        = 0,
    parameter logic [M-1:0]   TAPS_DEFAULT = 40'h9C00000001,
    parameter logic [M-1:0]   SEED_DEFAULT = 40'h0000000001,
    parameter int             HB_W         = 3,
    parameter int             HB_DIV       = 20
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_en,
    input  logic            cfg_i,
    output logic            cfg_o,
    input  logic            resync,
    input  logic            tx_valid,
    input  logic [W-1:0]    tx_p,
    output logic            tx_e_valid,
    output logic [W-1:0]    tx_e,
    input  logic            rx_valid,
    input  logic [W-1:0]    rx_e,
    output logic            rx_p_valid,
    output logic [W-1:0]    rx_p,
    output logic [1:0]      lock_err,
    output logic [HB_W-1:0] heartbeat
);

    localparam int           L           = CHAIN_PER_M * M;
    localparam int           HBC         = HB_DIV + HB_W;
    localparam logic [L-1:0] CHAIN_RESET = {TAPS_DEFAULT, SEED_DEFAULT, TAPS_DEFAULT, SEED_DEFAULT};

    logic [L-1:0]   chain_q, chain_d;
    logic           cfg_o_q, cfg_o_d;
    logic [HBC-1:0] hb_q, hb_d;

    logic [M-1:0]   tx_taps, tx_seed_next, rx_taps, rx_seed_next;
    logic           tx_lock, rx_lock;

    // Chain shifts MSB-first while cfg_en is high; heartbeat always counts.
    always_comb begin
        chain_d = chain_q;
        if (cfg_en) begin
            chain_d = {chain_q[L-2:0], cfg_i};
        end
        cfg_o_d = chain_q[L-1];
        hb_d    = hb_q + HBC'(1);
    end

    // Config chain, serial out flop and heartbeat counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain_q <= CHAIN_RESET;
            cfg_o_q <= 1'b0;
            hb_q    <= '0;
        end else begin
            chain_q <= chain_d;
            cfg_o_q <= cfg_o_d;
            hb_q    <= hb_d;
        end
    end

    assign tx_taps      = chain_q[4*M-1 -: M];
    assign tx_seed_next = chain_d[3*M-1 -: M];
    assign rx_taps      = chain_q[2*M-1 -: M];
    assign rx_seed_next = chain_d[M-1:0];

    xor_keystream_path #(
        .W            (W),
        .M            (M),
        .FRAME        (FRAME),
        .SEED_DEFAULT (SEED_DEFAULT)
    ) u_tx_path (
        .clk       (clk),
        .rst       (rst),
        .cfg_en    (cfg_en),
        .resync    (resync),
        .taps      (tx_taps),
        .seed      (tx_seed_next),
        .in_valid  (tx_valid),
        .in_data   (tx_p),
        .out_valid (tx_e_valid),
        .out_data  (tx_e),
        .lock_err  (tx_lock)
    );

    xor_keystream_path #(
        .W            (W),
        .M            (M),
        .FRAME        (FRAME),
        .SEED_DEFAULT (SEED_DEFAULT)
    ) u_rx_path (
        .clk       (clk),
        .rst       (rst),
        .cfg_en    (cfg_en),
        .resync    (resync),
        .taps      (rx_taps),
        .seed      (rx_seed_next),
        .in_valid  (rx_valid),
        .in_data   (rx_e),
        .out_valid (rx_p_valid),
        .out_data  (rx_p),
        .lock_err  (rx_lock)
    );

    assign cfg_o     = cfg_o_q;
    assign lock_err  = {rx_lock, tx_lock};
    assign heartbeat = hb_q[HBC-1 -: HB_W];

endmodule

// File: tb/tb_dual_xor_stream_cipher_w.sv
// Testbench for dual_xor_stream_cipher_w with M=8, W=8 and FRAME=4. A
// cycle-level reference model predicts every output after every clock edge.
module tb_dual_xor_stream_cipher_w;

    localparam int         W        = 8;
    localparam int         M        = 8;
    localparam int         FRAME    = 4;
    localparam int         HB_W     = 3;
    localparam int         HB_DIV   = 2;
    localparam logic [7:0] TAPS_DEF = 8'h8E;
    localparam logic [7:0] SEED_DEF = 8'h5A;

    logic            clk = 1'b0;
    logic            rst, cfg_en, cfg_i, cfg_o, resync;
    logic            tx_valid, tx_e_valid, rx_valid, rx_p_valid;
    logic [W-1:0]    tx_p, tx_e, rx_e, rx_p;
    logic [1:0]      lock_err;
    logic [HB_W-1:0] heartbeat;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_chain;
    logic [7:0]  m_state [2];
    int          m_frame [2];
    logic        m_lock  [2];
    logic        m_valid [2];
    logic [7:0]  m_data  [2];
    int          m_hb;
    logic        m_cfg_o;

    logic [7:0]  pt [16];
    logic [7:0]  ct;

    dual_xor_stream_cipher_w #(
        .W            (W),
        .M            (M),
        .FRAME        (FRAME),
        .TAPS_DEFAULT (TAPS_DEF),
        .SEED_DEFAULT (SEED_DEF),
        .HB_W         (HB_W),
        .HB_DIV       (HB_DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_en     (cfg_en),
        .cfg_i      (cfg_i),
        .cfg_o      (cfg_o),
        .resync     (resync),
        .tx_valid   (tx_valid),
        .tx_p       (tx_p),
        .tx_e_valid (tx_e_valid),
        .tx_e       (tx_e),
        .rx_valid   (rx_valid),
        .rx_e       (rx_e),
        .rx_p_valid (rx_p_valid),
        .rx_p       (rx_p),
        .lock_err   (lock_err),
        .heartbeat  (heartbeat)
    );

    // Free-running clock
    initial forever #5 clk = ~clk;

    // Keystream for one beat with plain arithmetic: returns {next_state, ks}
    function automatic logic [15:0] model_beat(input logic [7:0] s, input logic [7:0] taps);
        int st;
        int ks;
        int k;
        st = int'(s);
        ks = 0;
        for (int i = 0; i < 8; i++) begin
            k  = st % 2;
            st = (st / 2) ^ ((k != 0) ? int'(taps) : 0);
            ks = ks + k * (2 ** i);
        end
        return {8'(st), 8'(ks)};
    endfunction

    function automatic logic [7:0] taps_of(input int p);
        return (p == 0) ? m_chain[31:24] : m_chain[15:8];
    endfunction

    function automatic logic [7:0] seed_of(input int p);
        return (p == 0) ? m_chain[23:16] : m_chain[7:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_path(input int p, input bit v, input logic [7:0] d, input bit rs);
        logic [15:0] r;
        logic [7:0]  eff;
        eff = (m_state[p] == 8'h00) ? 8'h01 : m_state[p];
        if (m_state[p] == 8'h00) m_lock[p] = 1'b1;
        m_valid[p] = v;
        if (v) begin
            r = model_beat(eff, taps_of(p));
            m_data[p] = d ^ r[7:0];
            if (m_frame[p] == FRAME - 1) begin
                m_state[p] = seed_of(p);
                m_frame[p] = 0;
            end else begin
                m_state[p] = r[15:8];
                m_frame[p] = m_frame[p] + 1;
            end
        end
        if (rs) begin
            m_state[p] = seed_of(p);
            m_frame[p] = 0;
        end
    endtask

    task automatic check_output(input string tag);
        check({tag, ".tx_e_valid"}, 64'(tx_e_valid), 64'(m_valid[0]));
        check({tag, ".tx_e"},       64'(tx_e),       64'(m_data[0]));
        check({tag, ".rx_p_valid"}, 64'(rx_p_valid), 64'(m_valid[1]));
        check({tag, ".rx_p"},       64'(rx_p),       64'(m_data[1]));
        check({tag, ".lock_err"},   64'(lock_err),   64'({m_lock[1], m_lock[0]}));
        check({tag, ".heartbeat"},  64'(heartbeat),  64'((m_hb >> HB_DIV) % 8));
        check({tag, ".cfg_o"},      64'(cfg_o),      64'(m_cfg_o));
    endtask

    task automatic apply_stimulus(input bit txv, input logic [7:0] txd,
                                  input bit rxv, input logic [7:0] rxd, input bit rs);
        rst      = 1'b0;
        cfg_en   = 1'b0;
        cfg_i    = 1'b0;
        tx_valid = txv;
        tx_p     = txd;
        rx_valid = rxv;
        rx_e     = rxd;
        resync   = rs;
        m_cfg_o  = m_chain[31];
        model_path(0, txv, txd, rs);
        model_path(1, rxv, rxd, rs);
        m_hb = (m_hb + 1) % 32;
        tick();
        check_output("run");
    endtask

    task automatic config_shift(input bit b, input bit beat);
        rst      = 1'b0;
        cfg_en   = 1'b1;
        cfg_i    = b;
        tx_valid = beat;
        tx_p     = 8'($urandom);
        rx_valid = beat;
        rx_e     = 8'($urandom);
        resync   = 1'b0;
        m_cfg_o  = m_chain[31];
        m_chain  = {m_chain[30:0], b};
        for (int p = 0; p < 2; p++) begin
            m_state[p] = seed_of(p);
            m_frame[p] = 0;
            m_lock[p]  = 1'b0;
            m_valid[p] = 1'b0;
        end
        m_hb = (m_hb + 1) % 32;
        tick();
        check_output("cfg");
    endtask

    task automatic load_config(input logic [31:0] word);
        for (int i = 31; i >= 0; i--) begin
            config_shift(word[i], (i % 7) == 3);
        end
    endtask

    task automatic apply_reset(input bit beat);
        rst      = 1'b1;
        cfg_en   = 1'b0;
        cfg_i    = 1'b0;
        tx_valid = beat;
        tx_p     = 8'($urandom);
        rx_valid = beat;
        rx_e     = 8'($urandom);
        resync   = 1'b0;
        m_chain  = {TAPS_DEF, SEED_DEF, TAPS_DEF, SEED_DEF};
        for (int p = 0; p < 2; p++) begin
            m_state[p] = SEED_DEF;
            m_frame[p] = 0;
            m_lock[p]  = 1'b0;
            m_valid[p] = 1'b0;
            m_data[p]  = 8'h00;
        end
        m_hb    = 0;
        m_cfg_o = 1'b0;
        tick();
        check_output("reset");
    endtask

    // Directed scenarios followed by randomized traffic
    initial begin
        rst = 1'b1; cfg_en = 1'b0; cfg_i = 1'b0; resync = 1'b0;
        tx_valid = 1'b0; tx_p = '0; rx_valid = 1'b0; rx_e = '0;

        apply_reset(1'b0);
        check("reset.heartbeat", 64'(heartbeat), 64'(0));
        apply_stimulus(1'b1, 8'h3C, 1'b1, 8'hC3, 1'b0);

        // Load taps B8 / seed 01 on both paths; cfg_o replays the defaults
        load_config({8'hB8, 8'h01, 8'hB8, 8'h01});
        apply_stimulus(1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
        check("first.tx_e", 64'(tx_e), 64'(8'h71));
        check("first.tx_e_valid", 64'(tx_e_valid), 64'(1));
        apply_stimulus(1'b1, 8'h00, 1'b0, 8'h00, 1'b0);

        // Loopback TX ciphertext into RX
        apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        pt[0] = 8'hA5;
        for (int i = 1; i < 16; i++) pt[i] = 8'($urandom);
        apply_stimulus(1'b1, pt[0], 1'b0, 8'h00, 1'b0);
        ct = tx_e;
        for (int i = 1; i <= 16; i++) begin
            if (i < 16) apply_stimulus(1'b1, pt[i], 1'b1, ct, 1'b0);
            else        apply_stimulus(1'b0, 8'h00, 1'b1, ct, 1'b0);
            check("loop.rx_p", 64'(rx_p), 64'(pt[i-1]));
            ct = tx_e;
        end
        check("loop.lock_err", 64'(lock_err), 64'(0));

        // Frame wrap after 4 beats
        apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        apply_stimulus(1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
        check("frame.beat1", 64'(tx_e), 64'(8'h71));
        apply_stimulus(1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
        apply_stimulus(1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
        apply_stimulus(1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
        apply_stimulus(1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
        check("frame.beat5", 64'(tx_e), 64'(8'h71));

        // Resync alongside beat 2
        apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        apply_stimulus(1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
        apply_stimulus(1'b1, 8'h00, 1'b0, 8'h00, 1'b1);
        apply_stimulus(1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
        check("resync.beat3", 64'(tx_e), 64'(8'h71));

        // Randomized traffic on both paths
        for (int n = 0; n < 150; n++) begin
            apply_stimulus(1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom),
                           ($urandom % 16) == 0);
        end

        // Zero seed on TX: lock flag sets, first beat runs from state 01
        load_config({8'hB8, 8'h00, 8'hB8, 8'h01});
        apply_stimulus(1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
        check("zlock.tx_e", 64'(tx_e), 64'(8'h71));
        check("zlock.flag", 64'(lock_err), 64'(2'b01));
        apply_stimulus(1'b0, 8'h00, 1'b1, 8'h55, 1'b1);
        apply_stimulus(1'b1, 8'h12, 1'b0, 8'h00, 1'b0);
        config_shift(1'b1, 1'b1);
        check("zlock.clear", 64'(lock_err), 64'(0));
        load_config({8'hB8, 8'h01, 8'hB8, 8'h01});

        // Reset in the middle of traffic
        for (int n = 0; n < 5; n++) apply_stimulus(1'b1, 8'($urandom), 1'b1, 8'($urandom), 1'b0);
        apply_reset(1'b1);
        check("midreset.tx_e_valid", 64'(tx_e_valid), 64'(0));
        check("midreset.heartbeat", 64'(heartbeat), 64'(0));
        for (int n = 0; n < 40; n++) begin
            apply_stimulus(1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom),
                           ($urandom % 16) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dual_xor_stream_cipher_w.md
Name: dual_xor_stream_cipher_w

Overview:
- Parametrised successor to the bit-serial dual XOR stream cipher: one TX encrypt path and one RX decrypt path, each W bits per beat.
- Each path has its own M-bit Galois LFSR keystream with serially-loaded taps and seed, valid-qualified beats and a frame-based automatic reseed.
- Adds explicit resync, zero-lock protection with an error flag, and a divided heartbeat.
- Sits between a serial/parallel link front end and the host pins; configured over a single scan chain.

Parameters:
- W, 8, data bits per beat; the LFSR advances W steps per accepted beat.
- M, 40, LFSR length in bits.
- FRAME, 0, beats per frame before automatic reseed; 0 disables reseed.
- TAPS_DEFAULT, 40'h9C00000001, reset value of both tap registers (M bits).
- SEED_DEFAULT, 40'h0000000001, reset value of both seed registers (M bits).
- HB_W, 3, heartbeat output width.
- HB_DIV, 20, heartbeat divider exponent; the counter is HB_DIV+HB_W bits.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cfg_en  in  1  config chain shift enable; data paths held while high
- cfg_i  in  1  config serial in
- cfg_o  out  1  config serial out, chain MSB
- resync  in  1  pulse: reseed both LFSRs
- tx_valid  in  1  tx_p beat valid
- tx_p  in  W  plaintext
- tx_e_valid  out  1  tx_e valid
- tx_e  out  W  ciphertext
- rx_valid  in  1  rx_e beat valid
- rx_e  in  W  ciphertext
- rx_p_valid  out  1  rx_p valid
- rx_p  out  W  recovered plaintext
- lock_err  out  2  sticky zero-lock flag; bit0 = TX, bit1 = RX
- heartbeat  out  HB_W  top HB_W bits of the free-running counter

Behaviour:
- Reset:
  - Outputs: all outputs 0.
  - Config registers: taps = TAPS_DEFAULT, seeds = SEED_DEFAULT.
  - Internal state: LFSR states = seeds, frame counters 0, heartbeat counter 0.
  - rst overrides everything.
- Config chain: L = 4M bits, MSB first, ordered {tx_taps, tx_seed, rx_taps, rx_seed}.
  - While cfg_en = 1, each cycle: chain <= {chain[L-2:0], cfg_i}.
  - cfg_o = chain[L-1], registered.
- While cfg_en = 1 (CONFIG mode):
  - LFSR states are loaded raw from the seeds every cycle.
  - Frame counters are held at 0 and lock_err is cleared.
  - Input beats are dropped; tx_e_valid and rx_p_valid are 0.
- LFSR step, Galois right-shift: bit k = s[0]; s' = (s >> 1) ^ (s[0] ? taps : 0).
  - The beat keystream is bits k0..k(W-1) from W successive steps; data bit i is XORed with ki (LSB first).
  - All W steps are unrolled in one cycle.
- Zero-lock: each path computes from s_eff = (state == 0) ? 1 : state.
  - If cfg_en = 0 and state == 0, the path's lock_err bit sets (sticky until rst or cfg_en).
- Data path (cfg_en = 0), per path, latency 1:
  - On valid: output <= input ^ keystream(s_eff); out_valid <= 1; state <= s_eff advanced W steps; frame counter increments.
  - Without valid: out_valid <= 0, the data output holds its last value, and the state holds (s_eff substitution still applies).
- Frame wrap (FRAME > 0): on an accepted beat with counter == FRAME-1, the beat uses the current keystream, then state <= seed and counter <= 0.
- resync = 1 (cfg_en = 0): both paths reseed (state <= seed, counter <= 0).
  - Any beat in the same cycle is still processed with the current keystream; resync takes precedence over the normal advance and over frame wrap.
- Priority: rst > cfg_en > resync > frame wrap > normal advance.
- TX and RX are fully independent; simultaneous beats on both are legal.
- Heartbeat: the counter increments every cycle regardless of cfg_en and wraps modulo 2^(HB_DIV+HB_W).

Decomposition:
- Package cipher_pkg:
  - function lfsr_step(s, taps) returning {next_s, k};
  - function keystream_w(s, taps) returning {next_s, W-bit ks};
  - localparam CFG_LEN = 4*M.
- One sub-module, xor_keystream_path, instantiated twice (TX, RX). It holds state, frame counter, zero-lock flag and output registers; taps, seed, cfg_en and resync are inputs.
- The top level holds the config chain and the heartbeat counter.

Test Plan:
- M=8, W=8, taps 8'hB8, seed 8'h01 shifted in on both paths, cfg_en dropped; tx_valid with tx_p = 8'h00 -> tx_e = 8'h71 with tx_e_valid one cycle later; next state 8'h64.
- Loopback: drive rx_e with each tx_e for 16 beats, plaintext 8'hA5 .. -> rx_p equals the original plaintext each beat; lock_err = 0.
- FRAME=4: 5 beats of tx_p = 0 -> beats 1 and 5 both produce 8'h71; resync asserted with beat 2 -> beat 2 uses the normal keystream, beat 3 produces 8'h71.
- Seed 8'h00 loaded -> first RUN cycle sets lock_err[0], and the first beat uses state 01 (tx_e = 8'h71 for tx_p = 0); re-asserting cfg_en clears lock_err.
- Shift 32 bits with cfg_en high -> cfg_o replays the previous chain contents MSB-first; tx_valid pulses during cfg_en give no tx_e_valid.
- rst asserted mid-stream with tx_valid high -> next cycle all outputs 0, seeds and taps back to defaults, heartbeat 0.
